wb_repeat_regbank: RTL and testbench

- Parametrised Wishbone-slave register bank with N_CH repeated channels.
- Each channel has one RW control register (byte-select aware, with a write-strobe output) and one RO status register.
- Generalises the fixed two-instance repeat block: channel count and reset value are configurable; out-of-range accesses return an error.
- Sits between the Wishbone interconnect and per-channel user logic.

---
 rtl/wb_repeat_regbank.sv | 124 ++++++++++++
 tb/tb_wb_repeat_regbank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_repeat_regbank.sv
// Wishbone register bank with N_CH repeated channels: one RW control and one RO status word each.
// Define WB_REPEAT_REGBANK_STICKY_EN to turn status words into write-1-to-clear sticky registers.
module wb_repeat_regbank #(
  parameter int          N_CH     = 4,
  parameter logic [31:0] CTRL_RST = 32'h0,
  parameter int          ADR_W    = ($clog2(2*N_CH) + 2 < 3) ? 3 : $clog2(2*N_CH) + 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [ADR_W-1:2]   wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_dat_i,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic               wb_stall_o,
  output logic [31:0]        wb_dat_o,
  output logic [N_CH*32-1:0] ctrl_o,
  output logic [N_CH-1:0]    ctrl_wr_o,
  input  logic [N_CH*32-1:0] status_i
);

  localparam int            WW     = ADR_W - 2;
  localparam logic [WW:0]   N_CH_W = (WW+1)'(N_CH);

  logic          rip, wip;
  logic          rd_req, wr_req;
  logic          rd_ack_q, rd_err_q;
  logic [31:0]   dat_q;
  logic          wr_pend_q;
  logic [WW-1:0] wr_adr_q;
  logic [31:0]   wr_dat_q;
  logic [3:0]    wr_sel_q;

  logic [WW-1:0] rd_w, rd_chan, wr_chan;
  logic          rd_ok, wr_ok;
  logic [31:0]   wmask;
  logic [31:0]   rd_mux;
  logic [31:0]   ctrl_q [N_CH];
  logic [31:0]   st_val [N_CH];

  assign rd_req  = wb_cyc_i & wb_stb_i & ~wb_we_i & ~rip;
  assign wr_req  = wb_cyc_i & wb_stb_i &  wb_we_i & ~wip;

  assign rd_w    = wb_adr_i;
  assign rd_chan = rd_w >> 1;
  assign wr_chan = wr_adr_q >> 1;
  assign rd_ok   = {1'b0, rd_chan} < N_CH_W;
  assign wr_ok   = {1'b0, wr_chan} < N_CH_W;
  assign wmask   = {{8{wr_sel_q[3]}}, {8{wr_sel_q[2]}}, {8{wr_sel_q[1]}}, {8{wr_sel_q[0]}}};

  // Writes are decoded one cycle late from the captured request, so their response is combinational.
  assign wb_ack_o   = rd_ack_q | (wr_pend_q &  wr_ok);
  assign wb_err_o   = rd_err_q | (wr_pend_q & ~wr_ok);
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = ~(wb_ack_o | wb_err_o) & wb_cyc_i & wb_stb_i;
  assign wb_dat_o   = dat_q;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_chan == WW'(c)) rd_mux = rd_w[0] ? st_val[c] : ctrl_q[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rip       <= 1'b0;
      wip       <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      dat_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      wr_sel_q  <= '0;
    end else begin
      rd_ack_q  <= rd_req &  rd_ok;
      rd_err_q  <= rd_req & ~rd_ok;
      if (rd_req) dat_q <= rd_ok ? rd_mux : 32'h0;
      wr_pend_q <= wr_req;
      if (wr_req) begin
        wr_adr_q <= wb_adr_i;
        wr_dat_q <= wb_dat_i;
        wr_sel_q <= wb_sel_i;
      end
      if (rd_req)                     rip <= 1'b1;
      else if (wb_ack_o || wb_err_o)  rip <= 1'b0;
      if (wr_req)                     wip <= 1'b1;
      else if (wb_ack_o || wb_err_o)  wip <= 1'b0;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic hit;
    assign hit          = wr_pend_q & wr_ok & (wr_chan == WW'(c));
    assign ctrl_wr_o[c] = hit & ~wr_adr_q[0];
    assign ctrl_o[32*c +: 32] = ctrl_q[c];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)          ctrl_q[c] <= CTRL_RST;
      else if (ctrl_wr_o[c]) ctrl_q[c] <= (ctrl_q[c] & ~wmask) | (wr_dat_q & wmask);
    end

`ifdef WB_REPEAT_REGBANK_STICKY_EN
    logic [31:0] sticky_q;
    logic [31:0] clr;
    assign clr       = (hit & wr_adr_q[0]) ? (wr_dat_q & wmask) : 32'h0;
    assign st_val[c] = sticky_q;

    // Set is OR-ed in after the clear so a coinciding status bit survives.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sticky_q <= '0;
      else          sticky_q <= (sticky_q & ~clr) | status_i[32*c +: 32];
    end
`else
    assign st_val[c] = status_i[32*c +: 32];
`endif
  end

endmodule

// File: tb/tb_wb_repeat_regbank.sv
// Directed self-checking bench for wb_repeat_regbank (N_CH=3, CTRL_RST=0).
module tb_wb_repeat_regbank;
  localparam int N_CH = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cyc, stb, we;
  logic [4:2]    adr;
  logic [3:0]    sel;
  logic [31:0]   dat;
  logic          ack, err, rty, stall;
  logic [31:0]   rdat;
  logic [95:0]   ctrl;
  logic [2:0]    ctrl_wr;
  logic [95:0]   status;

  int errors = 0;
  int checks = 0;

  wb_repeat_regbank #(.N_CH(N_CH), .CTRL_RST(32'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_we_i(we), .wb_dat_i(dat),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall),
    .wb_dat_o(rdat), .ctrl_o(ctrl), .ctrl_wr_o(ctrl_wr), .status_i(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [2:0] w, input logic [31:0] ed,
                         input logic ea, input logic ee);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = w; sel = 4'h0;
    #1 chk({tag, " stall_n"}, 32'(stall), 32'h1);
    @(negedge clk);
    chk({tag, " ack"}, 32'(ack), 32'(ea));
    chk({tag, " err"}, 32'(err), 32'(ee));
    chk({tag, " dat"}, rdat, ed);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk({tag, " resp_n2"}, 32'({ack, err}), 32'h0);
  endtask

  task automatic do_write(input string tag, input logic [2:0] w, input logic [31:0] d,
                          input logic [3:0] s, input logic ea, input logic ee, input logic [2:0] ep);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = w; dat = d; sel = s;
    #1 chk({tag, " wr_n0"}, 32'(ctrl_wr), 32'h0);
    @(negedge clk);
    chk({tag, " ack"}, 32'(ack), 32'(ea));
    chk({tag, " err"}, 32'(err), 32'(ee));
    chk({tag, " ctrl_wr"}, 32'(ctrl_wr), 32'(ep));
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk({tag, " resp_n2"}, 32'({ack, err}), 32'h0);
    chk({tag, " ctrl_wr_n2"}, 32'(ctrl_wr), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat = '0;
    status = {32'h5A5A_0000, 32'h0000_00A5, 32'h0};

    #1;
    chk("rst ctrl0", ctrl[31:0], 32'h0);
    chk("rst ctrl1", ctrl[63:32], 32'h0);
    chk("rst ctrl2", ctrl[95:64], 32'h0);
    chk("rst ctrl_wr", 32'(ctrl_wr), 32'h0);
    chk("rst ack_err", 32'({ack, err}), 32'h0);
    chk("rst dat", rdat, 32'h0);
    chk("rst rty", 32'(rty), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_read("rd ctrl0", 3'd0, 32'h0, 1'b1, 1'b0);
    do_read("rd ctrl1", 3'd2, 32'h0, 1'b1, 1'b0);
    do_read("rd ctrl2", 3'd4, 32'h0, 1'b1, 1'b0);

    do_read("rd st1", 3'd3, 32'h0000_00A5, 1'b1, 1'b0);
    do_read("rd st2", 3'd5, 32'h5A5A_0000, 1'b1, 1'b0);

    do_write("wr ch2", 3'd4, 32'hDEAD_BEEF, 4'b0101, 1'b1, 1'b0, 3'b100);
    chk("ch2 ctrl", ctrl[95:64], 32'h00AD_00EF);
    chk("ch0 untouched", ctrl[31:0], 32'h0);
    chk("ch1 untouched", ctrl[63:32], 32'h0);
    do_read("rb ch2", 3'd4, 32'h00AD_00EF, 1'b1, 1'b0);

    do_write("wr ch0 full", 3'd0, 32'h1122_3344, 4'b1111, 1'b1, 1'b0, 3'b001);
    do_write("wr ch0 b3", 3'd0, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 3'b001);
    chk("ch0 ctrl", ctrl[31:0], 32'hFF22_3344);
    do_read("rb ch0", 3'd0, 32'hFF22_3344, 1'b1, 1'b0);

    do_write("wr st1", 3'd3, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, 3'b000);
    chk("st wr ctrl1", ctrl[63:32], 32'h0);
    do_read("rd st1 again", 3'd3, 32'h0000_00A5, 1'b1, 1'b0);

    do_read("oor rd w6", 3'd6, 32'h0, 1'b0, 1'b1);
    do_read("oor rd w7", 3'd7, 32'h0, 1'b0, 1'b1);
    do_write("oor wr w6", 3'd6, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 3'b000);
    chk("oor ctrl2", ctrl[95:64], 32'h00AD_00EF);
    chk("oor ctrl0", ctrl[31:0], 32'hFF22_3344);

`ifdef WB_REPEAT_REGBANK_STICKY_EN
    @(negedge clk); status[3] = 1'b1;
    @(negedge clk); status[3] = 1'b0;
    do_read("stk set", 3'd1, 32'h0000_0008, 1'b1, 1'b0);
    do_write("stk clr", 3'd1, 32'h0000_0008, 4'b1111, 1'b1, 1'b0, 3'b000);
    do_read("stk cleared", 3'd1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dat = 32'h0000_0008; sel = 4'b1111;
    @(negedge clk);
    status[3] = 1'b1;
    chk("stk coincide ack", 32'(ack), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    status[3] = 1'b0;
    do_read("stk set wins", 3'd1, 32'h0000_0008, 1'b1, 1'b0);
`else
    @(negedge clk); status[63:32] = 32'h0000_003C;
    do_read("live st1", 3'd3, 32'h0000_003C, 1'b1, 1'b0);
    @(negedge clk); status[3] = 1'b1;
    @(negedge clk); status[3] = 1'b0;
    do_read("live st0", 3'd1, 32'h0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd2; dat = 32'hCAFE_0001; sel = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ctrl0", ctrl[31:0], 32'h0);
    chk("async rst ctrl2", ctrl[95:64], 32'h0);
    @(negedge clk);
    chk("rst drop resp", 32'({ack, err}), 32'h0);
    chk("rst drop ctrl_wr", 32'(ctrl_wr), 32'h0);
    chk("rst drop ctrl1", ctrl[63:32], 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_write("post rst wr", 3'd2, 32'hCAFE_0001, 4'b1111, 1'b1, 1'b0, 3'b010);
    chk("post rst ctrl1", ctrl[63:32], 32'hCAFE_0001);
    do_read("post rst rb", 3'd2, 32'hCAFE_0001, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
